snoop_bus_mem: RTL and testbench

Shared-bus controller and main-memory responder for the three-processor MESI snooping system. It arbitrates issue requests round-robin and opens a fixed transaction window. It drives each processor's enable (`habilita`) and issuer/snooper select (`controleP`), and broadcasts the common `bus_in` word. It also holds the 8-word backing memory, supplying read-miss data and absorbing write-backs.

---
 rtl/snoop_bus_mem.sv | 163 ++++++++++++++++
 tb/tb_snoop_bus_mem.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_mem.sv
// Shared-bus controller and 8-word backing memory for a three-CPU MESI snooping system.
// Round-robin grant, fixed-length transaction window, registered bus word and enables.
module snoop_bus_mem #(
    parameter int ISSUE_CYCLES = 7,
    parameter int SNOOP_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [2:0]  req,
    input  logic [8:0]  req_tag,
    input  logic [29:0] cpu_bus_out,
    input  logic [2:0]  cpu_shared_out,
    output logic [9:0]  bus_in,
    output logic [2:0]  habilita,
    output logic [2:0]  controleP,
    output logic [2:0]  shared_in,
    output logic [2:0]  ack,
    output logic        busy
);

    typedef enum logic {IDLE, WINDOW} state_t;

    localparam logic [2:0] LAST_CNT = 3'(ISSUE_CYCLES - 1);
    localparam logic [2:0] RESP_CNT = 3'(SNOOP_CYCLES);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       g_q, g_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       tag_q, tag_d;
    logic [9:0]       bus_in_q, bus_in_d;
    logic [2:0]       habilita_q, habilita_d;
    logic [2:0]       controleP_q, controleP_d;
    logic [7:0][2:0]  mem_q, mem_d;

    logic [2:0]       tag_w [3];
    logic [9:0]       word_w [3];
    logic [1:0]       pick;
    logic             pick_found;
    logic [1:0]       cand;
    logic [9:0]       issuer_w;
    logic             s_found;
    logic [2:0]       s_data;
    logic [2:0]       g_onehot;

    assign tag_w[0]  = req_tag[2:0];
    assign tag_w[1]  = req_tag[5:3];
    assign tag_w[2]  = req_tag[8:6];
    assign word_w[0] = cpu_bus_out[9:0];
    assign word_w[1] = cpu_bus_out[19:10];
    assign word_w[2] = cpu_bus_out[29:20];

    assign g_onehot = 3'b001 << g_q;
    assign issuer_w = word_w[g_q];

    // Round-robin: scan last+1, last+2, last+3 (mod 3) for the first requester.
    always_comb begin
        pick       = 2'd0;
        pick_found = 1'b0;
        cand       = last_q;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    // Lowest-index snooper offering a write-back supplies the data.
    always_comb begin
        s_found = 1'b0;
        s_data  = 3'd0;
        for (logic [1:0] i = 2'd0; i < 2'd3; i++) begin
            if (i != g_q && !s_found && word_w[i][7:6] == 2'b10) begin
                s_found = 1'b1;
                s_data  = word_w[i][2:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        g_d      = g_q;
        last_d   = last_q;
        tag_d    = tag_q;
        bus_in_d = bus_in_q;
        mem_d    = mem_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = WINDOW;
                    cnt_d    = 3'd0;
                    g_d      = pick;
                    tag_d    = tag_w[pick];
                    bus_in_d = {4'b0000, tag_w[pick], 3'b000};
                end
            end
            WINDOW: begin
                if (cnt_q == LAST_CNT) begin
                    state_d  = IDLE;
                    last_d   = g_q;
                    bus_in_d = 10'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == RESP_CNT) begin
                        // Snooper write happens after the issuer eviction so it wins on a tag clash.
                        if (issuer_w[7:6] == 2'b10) mem_d[issuer_w[5:3]] = issuer_w[2:0];
                        if (s_found) mem_d[tag_q] = s_data;
                        if (issuer_w[9:8] == 2'b01)
                            bus_in_d = {4'b0001, tag_q, s_found ? s_data : mem_q[tag_q]};
                        else
                            bus_in_d = issuer_w;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        habilita_d  = 3'b000;
        controleP_d = 3'b000;
        if (state_d == WINDOW) begin
            controleP_d = 3'b001 << g_d;
            habilita_d  = (cnt_d < RESP_CNT ? 3'b111 : 3'b000) | (3'b001 << g_d);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            g_q         <= 2'd0;
            last_q      <= 2'd2;
            tag_q       <= 3'd0;
            bus_in_q    <= 10'd0;
            habilita_q  <= 3'b000;
            controleP_q <= 3'b000;
            for (int a = 0; a < 8; a++) mem_q[a] <= 3'(a);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            last_q      <= last_d;
            tag_q       <= tag_d;
            bus_in_q    <= bus_in_d;
            habilita_q  <= habilita_d;
            controleP_q <= controleP_d;
            mem_q       <= mem_d;
        end
    end

    assign bus_in    = bus_in_q;
    assign habilita  = habilita_q;
    assign controleP = controleP_q;
    assign busy      = (state_q == WINDOW);
    assign ack       = (state_q == WINDOW && cnt_q == LAST_CNT) ? g_onehot : 3'b000;
    assign shared_in = (state_q == WINDOW && (cpu_shared_out & ~g_onehot) != 3'b000)
                       ? g_onehot : 3'b000;

endmodule

// File: tb/tb_snoop_bus_mem.sv
// Bench for snoop_bus_mem: transaction-level model of arbitration, enables and memory.
module tb_snoop_bus_mem;

    localparam int WIN   = 7;
    localparam int SNOOP = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic [2:0]  req;
    logic [8:0]  req_tag;
    logic [29:0] cpu_bus_out;
    logic [2:0]  cpu_shared_out;
    logic [9:0]  bus_in;
    logic [2:0]  habilita, controleP, shared_in, ack;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] model_mem [8];
    int         model_last;
    logic [9:0] exp_q [$];

    always #5 clock = ~clock;

    snoop_bus_mem #(.ISSUE_CYCLES(WIN), .SNOOP_CYCLES(SNOOP)) dut (
        .clock(clock), .clear(clear), .req(req), .req_tag(req_tag),
        .cpu_bus_out(cpu_bus_out), .cpu_shared_out(cpu_shared_out),
        .bus_in(bus_in), .habilita(habilita), .controleP(controleP),
        .shared_in(shared_in), .ack(ack), .busy(busy)
    );

    function automatic logic [9:0] mk(input logic [1:0] bm, input logic [1:0] mm,
                                      input logic [2:0] t, input logic [2:0] d);
        return {bm, mm, t, d};
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 8; a++) model_mem[a] = 3'(a);
        model_last = 2;
    endtask

    // One full transaction: starts and ends at a negedge with the DUT in IDLE.
    task automatic run_txn(input logic [2:0] reqv, input logic [8:0] tags,
                           input logic [29:0] words, input bit drop_req);
        int g;
        logic [1:0] idx;
        logic [2:0] tag, s_data, e_hab, e_ctl, e_sh, e_ack;
        logic [9:0] w, wi, resp, e_bus;
        bit s_found;
        req = reqv; req_tag = tags; cpu_bus_out = words;
        cpu_shared_out = 3'($urandom_range(0, 7));
        #1;
        n_checks += 4;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy got %b exp 0", busy); end
        if (habilita !== 3'b000 || controleP !== 3'b000) begin
            n_errors++; $display("FAIL idle_en got hab=%b ctl=%b exp 000", habilita, controleP);
        end
        if (bus_in !== 10'h000) begin n_errors++; $display("FAIL idle_bus got %h exp 000", bus_in); end
        if (shared_in !== 3'b000 || ack !== 3'b000) begin
            n_errors++; $display("FAIL idle_sh_ack got sh=%b ack=%b exp 000", shared_in, ack);
        end

        g = -1;
        for (int k = 1; k <= 3; k++) begin
            idx = 2'((model_last + k) % 3);
            if (g < 0 && reqv[idx]) g = int'(idx);
        end
        tag = 3'(tags >> (3 * g));
        w   = 10'(words >> (10 * g));
        s_found = 0; s_data = 3'd0;
        for (int i = 0; i < 3; i++) begin
            wi = 10'(words >> (10 * i));
            if (i != g && !s_found && wi[7:6] == 2'b10) begin s_found = 1; s_data = wi[2:0]; end
        end
        if (w[9:8] == 2'b01) resp = {4'b0001, tag, s_found ? s_data : model_mem[tag]};
        else                 resp = w;
        if (w[7:6] == 2'b10) model_mem[w[5:3]] = w[2:0];
        if (s_found)         model_mem[tag] = s_data;
        for (int c = 0; c < WIN; c++) begin
            if (c < SNOOP) exp_q.push_back({4'b0000, tag, 3'b000});
            else if (c > SNOOP) exp_q.push_back(resp);
        end

        @(posedge clock);
        @(negedge clock);
        for (int c = 0; c < WIN; c++) begin
            cpu_shared_out = 3'($urandom_range(0, 7));
            #1;
            e_ctl = 3'(1 << g);
            e_hab = (c < SNOOP) ? 3'b111 : e_ctl;
            e_sh  = ((cpu_shared_out & ~e_ctl) != 3'b000) ? e_ctl : 3'b000;
            e_ack = (c == WIN - 1) ? e_ctl : 3'b000;
            n_checks += 5;
            if (habilita !== e_hab) begin
                n_errors++; $display("FAIL habilita cnt%0d got %b exp %b", c, habilita, e_hab);
            end
            if (controleP !== e_ctl) begin
                n_errors++; $display("FAIL controleP cnt%0d got %b exp %b", c, controleP, e_ctl);
            end
            if (shared_in !== e_sh) begin
                n_errors++; $display("FAIL shared_in cnt%0d got %b exp %b", c, shared_in, e_sh);
            end
            if (ack !== e_ack) begin
                n_errors++; $display("FAIL ack cnt%0d got %b exp %b", c, ack, e_ack);
            end
            if (busy !== 1'b1) begin
                n_errors++; $display("FAIL busy cnt%0d got %b exp 1", c, busy);
            end
            if (c != SNOOP) begin
                e_bus = exp_q.pop_front();
                n_checks++;
                if (bus_in !== e_bus) begin
                    n_errors++; $display("FAIL bus_in cnt%0d got %h exp %h", c, bus_in, e_bus);
                end
            end
            if (c == WIN - 1) begin
                model_last = g;
                req = drop_req ? 3'b000 : reqv;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        clear = 1'b0; req = 3'b000; req_tag = 9'd0; cpu_bus_out = 30'd0; cpu_shared_out = 3'b111;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        n_checks += 3;
        if (bus_in !== 10'h000 || busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_bus got bus=%h busy=%b exp 000/0", bus_in, busy);
        end
        if (habilita !== 3'b000 || controleP !== 3'b000) begin
            n_errors++; $display("FAIL reset_en got hab=%b ctl=%b exp 000", habilita, controleP);
        end
        if (shared_in !== 3'b000 || ack !== 3'b000) begin
            n_errors++; $display("FAIL reset_sh_ack got sh=%b ack=%b exp 000", shared_in, ack);
        end
        clear = 1'b1;
    endtask

    task automatic test_read_miss();
        run_txn(3'b001, {3'd0, 3'd0, 3'd5}, {10'h000, 10'h000, mk(2'b01, 2'b00, 3'd5, 3'd0)}, 1);
    endtask

    task automatic test_snoop_supply();
        run_txn(3'b001, {3'd0, 3'd0, 3'd5},
                {mk(2'b00, 2'b10, 3'd5, 3'd6), 10'h000, mk(2'b01, 2'b00, 3'd5, 3'd0)}, 1);
        run_txn(3'b001, {3'd0, 3'd0, 3'd5}, {10'h000, 10'h000, mk(2'b01, 2'b00, 3'd5, 3'd0)}, 1);
    endtask

    task automatic test_round_robin();
        clear = 1'b0;
        model_reset();
        @(negedge clock);
        clear = 1'b1;
        for (int n = 0; n < 4; n++)
            run_txn(3'b111, 9'($urandom), 30'($urandom), n == 3);
    endtask

    task automatic test_write_miss();
        run_txn(3'b001, {3'd0, 3'd0, 3'd3}, {10'h000, 10'h000, mk(2'b10, 2'b10, 3'd3, 3'd7)}, 1);
        run_txn(3'b001, {3'd0, 3'd0, 3'd3}, {10'h000, 10'h000, mk(2'b01, 2'b00, 3'd3, 3'd0)}, 1);
    endtask

    task automatic test_wb_conflict();
        run_txn(3'b001, {3'd0, 3'd0, 3'd2},
                {10'h000, mk(2'b00, 2'b10, 3'd6, 3'd4), mk(2'b11, 2'b10, 3'd2, 3'd1)}, 1);
        run_txn(3'b001, {3'd0, 3'd0, 3'd2}, {10'h000, 10'h000, mk(2'b01, 2'b00, 3'd2, 3'd0)}, 1);
    endtask

    task automatic test_reset_mid_window();
        req = 3'b010; req_tag = {3'd0, 3'd6, 3'd0};
        cpu_bus_out = {10'h000, mk(2'b10, 2'b10, 3'd1, 3'd5), 10'h000};
        @(posedge clock);
        @(negedge clock);
        repeat (3) @(negedge clock);
        cpu_shared_out = 3'b111;
        clear = 1'b0;
        #1;
        n_checks += 3;
        if (habilita !== 3'b000 || controleP !== 3'b000) begin
            n_errors++; $display("FAIL abort_en got hab=%b ctl=%b exp 000", habilita, controleP);
        end
        if (bus_in !== 10'h000 || busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_bus got bus=%h busy=%b exp 000/0", bus_in, busy);
        end
        if (ack !== 3'b000 || shared_in !== 3'b000) begin
            n_errors++; $display("FAIL abort_ack got ack=%b sh=%b exp 000", ack, shared_in);
        end
        req = 3'b000;
        model_reset();
        @(negedge clock);
        clear = 1'b1;
        run_txn(3'b111, {3'd0, 3'd0, 3'd3}, {10'h000, 10'h000, mk(2'b01, 2'b00, 3'd3, 3'd0)}, 1);
        run_txn(3'b010, {3'd0, 3'd1, 3'd0}, {10'h000, mk(2'b01, 2'b00, 3'd1, 3'd0), 10'h000}, 1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++)
            run_txn(3'($urandom_range(1, 7)), 9'($urandom), 30'($urandom),
                    (n == 23) ? 1'b1 : 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_miss();
        test_snoop_supply();
        test_round_robin();
        test_write_miss();
        test_wb_conflict();
        test_reset_mid_window();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
